if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the five-stage pipeline, directly upstream of the decode stage. It owns the program counter and fetches from instruction memory through a req/ready handshake that tolerates wait states. It applies decode-stage redirects (interrupt, exception, jr, j, taken branch) and hazard stalls, and drives the 64-bit IF_ID pipeline register that decode consumes.

## Interface
- RESET_PC, 32'h8000_0000, PC after reset
- INT_VECTOR, 32'h8000_0004, interrupt target
- EXC_VECTOR, 32'h8000_0008, undefined-instruction exception target
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- PC_IF_ID_Write  in  1  0 = decode stalled; freeze PC, IF_ID, and ignore all redirects
- interrupt, exception, JR, J, Z  in  1 each  redirect requests from decode
- jr_target, jump_target, branch_target  in  32 each  redirect addresses
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address, stable while imem_req=1 and imem_ready=0
- imem_ready  in  1  read data valid this cycle; may be combinational on imem_req
- imem_rdata  in  32  instruction word
- IF_PC  out  32  current PC (debug)
- IF_ID  out  64  [63:32] PC+4, [31:0] instruction

## Operation
- Redirect = PC_IF_ID_Write & (interrupt|exception|JR|J|Z). Target priority: INT_VECTOR > EXC_VECTOR > jr_target > jump_target > branch_target.
- Bubble = IF_ID <= {32'h8000_0000, 32'h0}. The instruction field is a nop. PC+4 bit 31 is set, so decode never raises interrupt on a bubble.
- States:
  - FETCH: imem_req=1, imem_addr=PC.
  - HOLD: word captured while stalled. imem_req=0. Word held in buf.
  - DISCARD: wrong-path request still outstanding. imem_req=1, imem_addr=stale_addr.
- FETCH, imem_ready=1:
  - Redirect: PC<=target, bubble.
  - Else write: IF_ID<={PC+4, rdata}, PC<=PC+4.
  - Else stalled: buf<=rdata, go to HOLD.
- FETCH, imem_ready=0:
  - Redirect: stale_addr<=PC, PC<=target, bubble, go to DISCARD.
  - Else write: bubble.
  - Else stalled: hold.
- HOLD, write:
  - Redirect: PC<=target, bubble, go to FETCH.
  - Else: IF_ID<={PC+4, buf}, PC<=PC+4, go to FETCH.
- HOLD, stalled: hold.
- DISCARD:
  - Data returned on imem_ready is dropped.
  - Go to FETCH on imem_ready.
  - Redirect here overwrites PC with the new target and stays in DISCARD until ready.
  - IF_ID gets a bubble on every write cycle.
- PC+4 is 32-bit modular; 32'hFFFF_FFFC wraps to 0.
- The memory handshake is never cancelled. An accepted address stays stable until ready.

## Timing
- Reset values: PC=RESET_PC, state=FETCH, IF_ID={32'h8000_0000,32'h0}, buf=0, stale_addr=0.
- After reset deasserts, imem_req=1 with imem_addr=RESET_PC in the same cycle.
- Zero-wait memory: the word at PC appears in IF_ID on the next edge, giving a throughput of one instruction per cycle.
- Each wait state adds one bubble.
- A redirect seen in cycle n:
  - The target is fetched in cycle n+1.
  - The instruction at the target is in IF_ID at the n+2 edge.
  - Exactly one bubble enters decode, provided memory has zero wait.
- A redirect arriving while PC_IF_ID_Write=0 has no effect. Decode re-presents it.
- Reset mid-fetch abandons the transaction: imem_req reflects the reset state immediately.

## Configuration
- IF_KERNEL_PROTECT_EN defined: the jr target's bit 31 is forced to jr_target[31] & PC[31]. User mode (PC[31]=0) cannot enter kernel space by jr. Other targets are used verbatim.
- Not defined: jr_target is used verbatim.

## Test plan
- Zero-wait memory, no redirects, reset released: IF_ID sequence {8000_0004, w0}, {8000_0008, w1}, … with one instruction per cycle.
- PC_IF_ID_Write=0 for 3 cycles while imem_ready=1: the word is captured in HOLD and imem_req=0. After release, IF_ID = that word. No word is lost or duplicated.
- J with jump_target=0000_0040 from PC 0000_0010: one bubble, then IF_ID={0000_0044, mem[0x40]}.
- interrupt and Z asserted in the same cycle: the next fetch address is 8000_0004. Z is ignored.
- imem_ready held low 2 cycles, then a branch redirect arrives: the state goes to DISCARD. imem_addr stays at the old PC until ready. The returned word is dropped, then the target is fetched.
- With IF_KERNEL_PROTECT_EN, PC=0000_0100, jr_target=8000_0200: the next imem_addr is 0000_0200. Without the macro it is 8000_0200.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ready handshake and drives IF_ID.
// Optional define IF_KERNEL_PROTECT_EN masks jr_target[31] with PC[31].
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter logic [31:0] INT_VECTOR = 32'h8000_0004,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PC_IF_ID_Write,
  input  logic        interrupt,
  input  logic        exception,
  input  logic        JR,
  input  logic        J,
  input  logic        Z,
  input  logic [31:0] jr_target,
  input  logic [31:0] jump_target,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_PC,
  output logic [63:0] IF_ID
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_HOLD,
    S_DISCARD
  } state_t;

  // Bubble carries PC+4 bit 31 set so decode never treats it as interruptible.
  localparam logic [63:0] BUBBLE = {32'h8000_0000, 32'h0000_0000};

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [63:0] r_if_id, w_if_id_nxt;
  logic [31:0] r_buf, w_buf_nxt;
  logic [31:0] r_stale_addr, w_stale_nxt;

  logic        w_redirect;
  logic [31:0] w_jr_target;
  logic [31:0] w_target;
  logic [31:0] w_pc_plus4;

  always_comb begin
`ifdef IF_KERNEL_PROTECT_EN
    w_jr_target = {jr_target[31] & r_pc[31], jr_target[30:0]};
`else
    w_jr_target = jr_target;
`endif
  end

  always_comb begin
    w_redirect = PC_IF_ID_Write & (interrupt | exception | JR | J | Z);
    w_pc_plus4 = r_pc + 32'd4;
    if (interrupt)      w_target = INT_VECTOR;
    else if (exception) w_target = EXC_VECTOR;
    else if (JR)        w_target = w_jr_target;
    else if (J)         w_target = jump_target;
    else                w_target = branch_target;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_if_id_nxt = r_if_id;
    w_buf_nxt   = r_buf;
    w_stale_nxt = r_stale_addr;
    imem_req    = 1'b1;
    imem_addr   = r_pc;
    unique case (r_state)
      S_FETCH: begin
        if (imem_ready) begin
          if (w_redirect) begin
            w_pc_nxt    = w_target;
            w_if_id_nxt = BUBBLE;
          end else if (PC_IF_ID_Write) begin
            w_if_id_nxt = {w_pc_plus4, imem_rdata};
            w_pc_nxt    = w_pc_plus4;
          end else begin
            w_buf_nxt   = imem_rdata;
            w_state_nxt = S_HOLD;
          end
        end else begin
          if (w_redirect) begin
            // Outstanding request cannot be cancelled; remember its address to finish it.
            w_stale_nxt = r_pc;
            w_pc_nxt    = w_target;
            w_if_id_nxt = BUBBLE;
            w_state_nxt = S_DISCARD;
          end else if (PC_IF_ID_Write) begin
            w_if_id_nxt = BUBBLE;
          end
        end
      end
      S_HOLD: begin
        imem_req = 1'b0;
        if (PC_IF_ID_Write) begin
          if (w_redirect) begin
            w_pc_nxt    = w_target;
            w_if_id_nxt = BUBBLE;
          end else begin
            w_if_id_nxt = {w_pc_plus4, r_buf};
            w_pc_nxt    = w_pc_plus4;
          end
          w_state_nxt = S_FETCH;
        end
      end
      S_DISCARD: begin
        imem_addr = r_stale_addr;
        if (PC_IF_ID_Write) begin
          w_if_id_nxt = BUBBLE;
          if (w_redirect) w_pc_nxt = w_target;
        end
        if (imem_ready) w_state_nxt = S_FETCH;
      end
      default: w_state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_PC;
      r_if_id      <= BUBBLE;
      r_buf        <= '0;
      r_stale_addr <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_if_id      <= w_if_id_nxt;
      r_buf        <= w_buf_nxt;
      r_stale_addr <= w_stale_nxt;
    end
  end

  assign IF_PC = r_pc;
  assign IF_ID = r_if_id;

endmodule

// File: tb/tb_if_stage.sv
// Directed table-driven bench for if_stage with a combinational zero/N-wait memory model.
module tb_if_stage;

  localparam logic [31:0] K = 32'h1234_5678;
  localparam logic [63:0] B = {32'h8000_0000, 32'h0};
`ifdef IF_KERNEL_PROTECT_EN
  localparam logic [31:0] JRP = 32'h0000_0200;
`else
  localparam logic [31:0] JRP = 32'h8000_0200;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr = 1'b1, intr = 1'b0, exc = 1'b0, jr = 1'b0, jj = 1'b0, zz = 1'b0, rdy = 1'b1;
  logic [31:0] jrt = '0, jt = '0, bt = '0;
  logic        imem_req;
  logic [31:0] imem_addr, imem_rdata, IF_PC;
  logic [63:0] IF_ID;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [6:0]  ctl;   // {wr, intr, exc, jr, j, z, ready}
    logic [31:0] jrt, jt, bt;
    logic        req;
    logic [31:0] addr;
    logic [63:0] ifid;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl[$];

  if_stage dut (
    .clk(clk), .reset(reset), .PC_IF_ID_Write(wr),
    .interrupt(intr), .exception(exc), .JR(jr), .J(jj), .Z(zz),
    .jr_target(jrt), .jump_target(jt), .branch_target(bt),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(rdy),
    .imem_rdata(imem_rdata), .IF_PC(IF_PC), .IF_ID(IF_ID)
  );

  always #5 clk = ~clk;

  // Garbage while idle, so a held word must come from the stage's own buffer.
  assign imem_rdata = imem_req ? (imem_addr ^ K) : 32'hDEAD_BEEF;

  function automatic logic [31:0] w(input logic [31:0] a);
    return a ^ K;
  endfunction

  function automatic vec_t mk(input logic [6:0] c, input logic [31:0] a_jrt, a_jt, a_bt,
                              input logic r, input logic [31:0] a, input logic [63:0] f,
                              input logic [31:0] p);
    vec_t v;
    v.ctl = c; v.jrt = a_jrt; v.jt = a_jt; v.bt = a_bt;
    v.req = r; v.addr = a; v.ifid = f; v.pc = p;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    tbl.push_back(mk(7'b1000001, 0, 0, 0, 1, 32'h8000_0000, {32'h8000_0004, w(32'h8000_0000)}, 32'h8000_0004));
    tbl.push_back(mk(7'b1000001, 0, 0, 0, 1, 32'h8000_0004, {32'h8000_0008, w(32'h8000_0004)}, 32'h8000_0008));
    tbl.push_back(mk(7'b1000101, 0, 32'h10, 0, 1, 32'h8000_0008, B, 32'h10));
    tbl.push_back(mk(7'b1000101, 0, 32'h40, 0, 1, 32'h10, B, 32'h40));
    tbl.push_back(mk(7'b1000001, 0, 0, 0, 1, 32'h40, {32'h44, w(32'h40)}, 32'h44));
    tbl.push_back(mk(7'b1100011, 0, 0, 32'h100, 1, 32'h44, B, 32'h8000_0004));
    tbl.push_back(mk(7'b1000001, 0, 0, 0, 1, 32'h8000_0004, {32'h8000_0008, w(32'h8000_0004)}, 32'h8000_0008));
    tbl.push_back(mk(7'b1011101, 32'h200, 32'h300, 0, 1, 32'h8000_0008, B, 32'h8000_0008));
    tbl.push_back(mk(7'b1001101, 32'h200, 32'h300, 0, 1, 32'h8000_0008, B, 32'h200));
    tbl.push_back(mk(7'b1000111, 0, 32'h300, 32'h400, 1, 32'h200, B, 32'h300));
    tbl.push_back(mk(7'b1000011, 0, 0, 32'h400, 1, 32'h300, B, 32'h400));
    tbl.push_back(mk(7'b1000001, 0, 0, 0, 1, 32'h400, {32'h404, w(32'h400)}, 32'h404));
    tbl.push_back(mk(7'b0000101, 0, 32'h40, 0, 1, 32'h404, {32'h404, w(32'h400)}, 32'h404));
    tbl.push_back(mk(7'b0100001, 0, 0, 0, 0, 32'h0, {32'h404, w(32'h400)}, 32'h404));
    tbl.push_back(mk(7'b0000000, 0, 0, 0, 0, 32'h0, {32'h404, w(32'h400)}, 32'h404));
    tbl.push_back(mk(7'b1000001, 0, 0, 0, 0, 32'h0, {32'h408, w(32'h404)}, 32'h408));
    tbl.push_back(mk(7'b1000001, 0, 0, 0, 1, 32'h408, {32'h40C, w(32'h408)}, 32'h40C));
    tbl.push_back(mk(7'b1000000, 0, 0, 0, 1, 32'h40C, B, 32'h40C));
    tbl.push_back(mk(7'b1000000, 0, 0, 0, 1, 32'h40C, B, 32'h40C));
    tbl.push_back(mk(7'b1000010, 0, 0, 32'h500, 1, 32'h40C, B, 32'h500));
    tbl.push_back(mk(7'b1000000, 0, 0, 0, 1, 32'h40C, B, 32'h500));
    tbl.push_back(mk(7'b1000001, 0, 0, 0, 1, 32'h40C, B, 32'h500));
    tbl.push_back(mk(7'b1000001, 0, 0, 0, 1, 32'h500, {32'h504, w(32'h500)}, 32'h504));
    tbl.push_back(mk(7'b1000100, 0, 32'h600, 0, 1, 32'h504, B, 32'h600));
    tbl.push_back(mk(7'b1100000, 0, 0, 0, 1, 32'h504, B, 32'h8000_0004));
    tbl.push_back(mk(7'b0000000, 0, 0, 0, 1, 32'h504, B, 32'h8000_0004));
    tbl.push_back(mk(7'b0000001, 0, 0, 0, 1, 32'h504, B, 32'h8000_0004));
    tbl.push_back(mk(7'b1000001, 0, 0, 0, 1, 32'h8000_0004, {32'h8000_0008, w(32'h8000_0004)}, 32'h8000_0008));
    tbl.push_back(mk(7'b0000001, 0, 0, 0, 1, 32'h8000_0008, {32'h8000_0008, w(32'h8000_0004)}, 32'h8000_0008));
    tbl.push_back(mk(7'b1000101, 0, 32'h700, 0, 0, 32'h0, B, 32'h700));
    tbl.push_back(mk(7'b1000001, 0, 0, 0, 1, 32'h700, {32'h704, w(32'h700)}, 32'h704));
    tbl.push_back(mk(7'b0000000, 0, 0, 0, 1, 32'h704, {32'h704, w(32'h700)}, 32'h704));
    tbl.push_back(mk(7'b1000101, 0, 32'hFFFF_FFFC, 0, 1, 32'h704, B, 32'hFFFF_FFFC));
    tbl.push_back(mk(7'b1000001, 0, 0, 0, 1, 32'hFFFF_FFFC, {32'h0, w(32'hFFFF_FFFC)}, 32'h0));
    tbl.push_back(mk(7'b1001001, 32'h8000_0200, 0, 0, 1, 32'h0, B, JRP));
    tbl.push_back(mk(7'b1000001, 0, 0, 0, 1, JRP, {JRP + 32'd4, w(JRP)}, JRP + 32'd4));

    // Reset state, then the first fetch address right after deassertion.
    repeat (2) @(posedge clk);
    #1;
    chk("reset req", {63'd0, imem_req}, 64'd1);
    chk("reset addr", {32'd0, imem_addr}, {32'd0, 32'h8000_0000});
    chk("reset IF_ID", IF_ID, B);
    chk("reset IF_PC", {32'd0, IF_PC}, {32'd0, 32'h8000_0000});
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i]) begin
      {wr, intr, exc, jr, jj, zz, rdy} = tbl[i].ctl;
      jrt = tbl[i].jrt; jt = tbl[i].jt; bt = tbl[i].bt;
      #1;
      chk($sformatf("v%0d req", i), {63'd0, imem_req}, {63'd0, tbl[i].req});
      if (tbl[i].req)
        chk($sformatf("v%0d addr", i), {32'd0, imem_addr}, {32'd0, tbl[i].addr});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d IF_ID", i), IF_ID, tbl[i].ifid);
      chk($sformatf("v%0d IF_PC", i), {32'd0, IF_PC}, {32'd0, tbl[i].pc});
      @(negedge clk);
    end

    // Asynchronous reset while parked in HOLD: request must come back immediately.
    {wr, intr, exc, jr, jj, zz, rdy} = 7'b0000001;
    @(posedge clk);
    #1;
    chk("hold req", {63'd0, imem_req}, 64'd0);
    #2 reset = 1'b1;
    #1;
    chk("async reset req", {63'd0, imem_req}, 64'd1);
    chk("async reset addr", {32'd0, imem_addr}, {32'd0, 32'h8000_0000});
    chk("async reset IF_ID", IF_ID, B);
    chk("async reset IF_PC", {32'd0, IF_PC}, {32'd0, 32'h8000_0000});
    @(negedge clk);
    reset = 1'b0;
    wr = 1'b1;
    @(posedge clk);
    #1;
    chk("post reset IF_ID", IF_ID, {32'h8000_0004, w(32'h8000_0000)});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
